// File: rtl/clock_pkg.sv
// Shared constants for the HH:MM time-setting controller and its BCD field counters.
package clock_pkg;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] EDIT_HR  = 2'd1;
    localparam logic [1:0] EDIT_MIN = 2'd2;
    localparam logic [1:0] COMMIT   = 2'd3;

    localparam logic [3:0]  BLANK_CODE = 4'hF;
    localparam int unsigned HR_MAX     = 23;
    localparam int unsigned MIN_MAX    = 59;

    // True when both digits are decimal and the two-digit value does not exceed max.
    function automatic logic bcd2_valid(input logic [7:0] v, input int unsigned max);
        int unsigned tens;
        int unsigned units;
        tens  = 32'(v[7:4]);
        units = 32'(v[3:0]);
        return (tens <= 9) && (units <= 9) && ((tens * 10 + units) <= max);
    endfunction

endpackage

// File: rtl/bcd2_updown.sv
// Two-digit BCD up/down counter wrapping between 00 and MAX; loads clamp out-of-range values to 00.
module bcd2_updown #(
    parameter int unsigned MAX = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [7:0] val_o,
    output logic [7:0] nxt_o
);
    import clock_pkg::*;

    localparam logic [7:0] MAX_BCD = {4'(MAX / 10), 4'(MAX % 10)};

    logic [7:0] val_q;
    logic [7:0] val_d;

    always_comb begin
        val_d = val_q;
        if (load_i) begin
            val_d = bcd2_valid(load_val_i, MAX) ? load_val_i : 8'h00;
        end else if (inc_i && !dec_i) begin
            if (val_q == MAX_BCD)        val_d = 8'h00;
            else if (val_q[3:0] == 4'd9) val_d = {val_q[7:4] + 4'd1, 4'd0};
            else                         val_d = {val_q[7:4], val_q[3:0] + 4'd1};
        end else if (dec_i && !inc_i) begin
            if (val_q == 8'h00)          val_d = MAX_BCD;
            else if (val_q[3:0] == 4'd0) val_d = {val_q[7:4] - 4'd1, 4'd9};
            else                         val_d = {val_q[7:4], val_q[3:0] - 4'd1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) val_q <= 8'h00;
        else       val_q <= val_d;
    end

    assign val_o = val_q;
    assign nxt_o = val_d;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: snapshot running time, edit hours then minutes with blink, commit via load strobe.
// state    | meaning
// RUN      | display follows running time, waiting for mode
// EDIT_HR  | hours field editable and blinking
// EDIT_MIN | minutes field editable and blinking
// COMMIT   | one-cycle load strobe of the edited time
module clock_set_ctrl #(
    parameter int unsigned BLINK_MAX   = 50_000_000,
    parameter int unsigned TIMEOUT_SEC = 10,
    parameter logic [3:0]  BLANK_CODE  = clock_pkg::BLANK_CODE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_cancel,
    input  logic [3:0] time_in_0,
    input  logic [3:0] time_in_1,
    input  logic [3:0] time_in_2,
    input  logic [3:0] time_in_3,
    output logic       load,
    output logic [3:0] load_time_0,
    output logic [3:0] load_time_1,
    output logic [3:0] load_time_2,
    output logic [3:0] load_time_3,
    output logic [3:0] disp_time_0,
    output logic [3:0] disp_time_1,
    output logic [3:0] disp_time_2,
    output logic [3:0] disp_time_3,
    output logic       edit_active,
    output logic [1:0] state_o
);
    import clock_pkg::*;

    localparam int unsigned BW = (BLINK_MAX > 1) ? $clog2(BLINK_MAX) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_SEC + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MAX - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_SEC - 1);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;
    logic          load_q, load_d;
    logic [15:0]   load_time_q, load_time_d;
    logic [15:0]   disp_q, disp_d;
    logic          edit_active_q, edit_active_d;

    logic        in_edit, next_edit, any_btn, adj, snap;
    logic [7:0]  hr_q, hr_nxt, min_q, min_nxt;
    logic [15:0] snap_val, edit_val;

    assign snap_val  = {time_in_0, time_in_1, time_in_2, time_in_3};
    assign in_edit   = (state_q == EDIT_HR) || (state_q == EDIT_MIN);
    assign next_edit = (state_d == EDIT_HR) || (state_d == EDIT_MIN);
    assign any_btn   = btn_mode | btn_inc | btn_dec | btn_cancel;
    assign snap      = (state_q == RUN) && btn_mode;
    // inc/dec only count when neither cancel nor mode claims the cycle
    assign adj       = in_edit && !btn_cancel && !btn_mode && (btn_inc || btn_dec);

    bcd2_updown #(.MAX(HR_MAX)) u_hours (
        .clk        (clk),
        .reset      (reset),
        .load_i     (snap),
        .load_val_i (snap_val[15:8]),
        .inc_i      (adj && (state_q == EDIT_HR) && btn_inc),
        .dec_i      (adj && (state_q == EDIT_HR) && btn_dec),
        .val_o      (hr_q),
        .nxt_o      (hr_nxt)
    );

    bcd2_updown #(.MAX(MIN_MAX)) u_minutes (
        .clk        (clk),
        .reset      (reset),
        .load_i     (snap),
        .load_val_i (snap_val[7:0]),
        .inc_i      (adj && (state_q == EDIT_MIN) && btn_inc),
        .dec_i      (adj && (state_q == EDIT_MIN) && btn_dec),
        .val_o      (min_q),
        .nxt_o      (min_nxt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: if (btn_mode) state_d = EDIT_HR;
            EDIT_HR, EDIT_MIN: begin
                if (btn_cancel)    state_d = RUN;
                else if (btn_mode) state_d = (state_q == EDIT_HR) ? EDIT_MIN : COMMIT;
                else if (tick_1hz && !any_btn && (tmo_q == TMO_LAST)) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        tmo_d = tmo_q;
        if (!next_edit || any_btn) tmo_d = '0;
        else if (tick_1hz)         tmo_d = tmo_q + 1'b1;

        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_on_d  = blink_on_q;
        if (!next_edit || (state_d != state_q) || adj) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = !blink_on_q;
        end
    end

    // Display uses next-state values so edits and blink changes show on the same edge
    always_comb begin
        edit_val = {hr_nxt, min_nxt};
        case (state_d)
            EDIT_HR:  disp_d = blink_on_d ? edit_val : {BLANK_CODE, BLANK_CODE, min_nxt};
            EDIT_MIN: disp_d = blink_on_d ? edit_val : {hr_nxt, BLANK_CODE, BLANK_CODE};
            COMMIT:   disp_d = edit_val;
            default:  disp_d = snap_val;
        endcase
        load_d        = (state_d == COMMIT);
        load_time_d   = load_d ? {hr_q, min_q} : load_time_q;
        edit_active_d = next_edit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            tmo_q         <= '0;
            blink_cnt_q   <= '0;
            blink_on_q    <= 1'b1;
            load_q        <= 1'b0;
            load_time_q   <= '0;
            disp_q        <= '0;
            edit_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmo_q         <= tmo_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_on_q    <= blink_on_d;
            load_q        <= load_d;
            load_time_q   <= load_time_d;
            disp_q        <= disp_d;
            edit_active_q <= edit_active_d;
        end
    end

    assign state_o     = state_q;
    assign edit_active = edit_active_q;
    assign load        = load_q;
    assign load_time_0 = load_time_q[15:12];
    assign load_time_1 = load_time_q[11:8];
    assign load_time_2 = load_time_q[7:4];
    assign load_time_3 = load_time_q[3:0];
    assign disp_time_0 = disp_q[15:12];
    assign disp_time_1 = disp_q[11:8];
    assign disp_time_2 = disp_q[7:4];
    assign disp_time_3 = disp_q[3:0];

endmodule
